// File: rtl/bmem_responder_if.sv
// Line-granular burst-memory port between an initiator (cpu) and bmem_responder.
// The initiator holds a request until it sees bmem_ready and keeps bmem_write high for all 4 beats.
interface bmem_responder_if;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/bmem_responder.sv
// Burst-memory responder: 4-beat line writes into an internal array, and in-order 4-beat
// read bursts returned after a fixed latency through a queue of line snapshots.
module bmem_responder #(
  parameter int unsigned MEM_LINES = 256,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned QDEPTH    = 4
) (
  input logic             clk,
  input logic             rst,
  bmem_responder_if.slave bus
);
  localparam int unsigned IdxW = $clog2(MEM_LINES);
  localparam int unsigned QaW  = $clog2(QDEPTH);
  localparam int unsigned PtrW = QaW + 1;
  localparam int unsigned CntW = $clog2(LATENCY);
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  logic [255:0]    mem [MEM_LINES];
  logic [IdxW-1:0] req_idx;
  logic            acc_wr, acc_rd;
  logic            ready_q, ready_d;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.bmem_addr[4:0];

  assign req_idx = bus.bmem_addr[5+IdxW-1:5];
  // Write wins when both strobes are high; the read is dropped.
  assign acc_wr  = ready_q && bus.bmem_write;
  assign acc_rd  = ready_q && bus.bmem_read && !bus.bmem_write;

  // Write path
  logic [1:0]      wr_beat_q, wr_beat_d;
  logic [191:0]    wbuf_q;
  logic [IdxW-1:0] widx_q;
  logic            mem_we;

  always_comb begin
    wr_beat_d = wr_beat_q;
    mem_we    = 1'b0;
    if (wr_beat_q != 2'd0) begin
      wr_beat_d = wr_beat_q + 2'd1;
      mem_we    = (wr_beat_q == 2'd3);
    end else if (acc_wr) begin
      wr_beat_d = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_wr) begin
      wbuf_q[63:0] <= bus.bmem_wdata;
      widx_q       <= req_idx;
    end else if (wr_beat_q == 2'd1) begin
      wbuf_q[127:64] <= bus.bmem_wdata;
    end else if (wr_beat_q == 2'd2) begin
      wbuf_q[191:128] <= bus.bmem_wdata;
    end
    if (mem_we) mem[widx_q] <= {bus.bmem_wdata, wbuf_q};
  end

  // Read queue
  logic [26:0]     q_addr [QDEPTH];
  logic [255:0]    q_line [QDEPTH];
  logic [CntW-1:0] q_cnt  [QDEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nx;
  logic [QaW-1:0]  wr_idx, head, next;
  logic            q_empty, full_d, next_valid, pop;

  assign wr_idx     = wr_ptr_q[QaW-1:0];
  assign head       = rd_ptr_q[QaW-1:0];
  assign rd_ptr_nx  = rd_ptr_q + PtrW'(1);
  assign next       = rd_ptr_nx[QaW-1:0];
  assign q_empty    = (wr_ptr_q == rd_ptr_q);
  assign next_valid = (wr_ptr_q != rd_ptr_nx);
  assign wr_ptr_d   = wr_ptr_q + PtrW'(acc_rd);
  assign rd_ptr_d   = pop ? rd_ptr_nx : rd_ptr_q;
  assign full_d     = (wr_ptr_d[QaW] != rd_ptr_d[QaW]) &&
                      (wr_ptr_d[QaW-1:0] == rd_ptr_d[QaW-1:0]);
  assign ready_d    = !full_d && (wr_beat_d == 2'd0);

  // Snapshot at accept keeps reads ordered against later writes.
  always_ff @(posedge clk) begin
    if (acc_rd) begin
      q_addr[wr_idx] <= bus.bmem_addr[31:5];
      q_line[wr_idx] <= mem[req_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < QDEPTH; i++) q_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (acc_rd && QaW'(i) == wr_idx) q_cnt[i] <= CntInit;
        else if (q_cnt[i] != '0)         q_cnt[i] <= q_cnt[i] - CntW'(1);
      end
    end
  end

  // Output engine
  state_e      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic        rvalid_q, rvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic [31:0] raddr_q, raddr_d;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    pop      = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    raddr_d  = raddr_q;
    case (state_q)
      StIdle: begin
        if (!q_empty && q_cnt[head] == '0) begin
          state_d  = StBurst;
          beat_d   = 2'd0;
          rvalid_d = 1'b1;
          rdata_d  = q_line[head][63:0];
          raddr_d  = {q_addr[head], 5'd0};
        end
      end
      StBurst: begin
        if (beat_q != 2'd3) begin
          beat_d   = beat_q + 2'd1;
          rvalid_d = 1'b1;
          rdata_d  = q_line[head][{beat_d, 6'd0} +: 64];
        end else begin
          pop = 1'b1;
          // Chain straight into the next burst when it is already due.
          if (next_valid && q_cnt[next] == '0) begin
            beat_d   = 2'd0;
            rvalid_d = 1'b1;
            rdata_d  = q_line[next][63:0];
            raddr_d  = {q_addr[next], 5'd0};
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      beat_q    <= 2'd0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wr_beat_q <= 2'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_beat_q <= wr_beat_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.bmem_ready  = ready_q;
  assign bus.bmem_rvalid = rvalid_q;
  assign bus.bmem_rdata  = rdata_q;
  assign bus.bmem_raddr  = raddr_q;

endmodule

// File: tb/tb_bmem_responder.sv
// Randomized bench for bmem_responder against a schedule-level model: line memory,
// expected beat timeline, outstanding-read count and write-beat phase.
module tb_bmem_responder;
  localparam int unsigned MemLines = 256;
  localparam int unsigned Latency  = 4;
  localparam int unsigned QDepth   = 4;

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [63:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bmem_responder_if bus();

  bmem_responder #(
    .MEM_LINES(MemLines),
    .LATENCY  (Latency),
    .QDEPTH   (QDepth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int           cyc = 0;
  logic [255:0] mmem [MemLines];
  beat_t        exp_q[$];
  int           pops[$];
  int           outstanding = 0;
  int           next_free = 0;
  int           wr_phase = 0;
  logic [255:0] wbuf;
  int           widx;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) % MemLines);
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle();
    bus.bmem_read  = 1'b0;
    bus.bmem_write = 1'b0;
  endtask

  // One clock: model what the edge accepts, then compare outputs 1ns later.
  task automatic step();
    logic  rdy_pre;
    int    st;
    beat_t b;
    rdy_pre = bus.bmem_ready;
    @(posedge clk);
    cyc++;
    if (wr_phase != 0) begin
      wbuf[wr_phase*64 +: 64] = bus.bmem_wdata;
      if (wr_phase == 3) begin
        mmem[widx] = wbuf;
        wr_phase = 0;
      end else begin
        wr_phase++;
      end
    end else if (rdy_pre && bus.bmem_write) begin
      wbuf[63:0] = bus.bmem_wdata;
      widx       = line_of(bus.bmem_addr);
      wr_phase   = 1;
    end else if (rdy_pre && bus.bmem_read) begin
      st = (cyc + Latency > next_free) ? cyc + Latency : next_free;
      next_free = st + 4;
      for (int k = 0; k < 4; k++) begin
        b.c = st + k;
        b.a = {bus.bmem_addr[31:5], 5'd0};
        b.d = mmem[line_of(bus.bmem_addr)][k*64 +: 64];
        exp_q.push_back(b);
      end
      pops.push_back(st + 4);
      outstanding++;
    end
    while (pops.size() > 0 && pops[0] == cyc) begin
      void'(pops.pop_front());
      outstanding--;
    end
    #1;
    check_eq("ready", bus.bmem_ready, (wr_phase == 0 && outstanding < QDepth));
    if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
      b = exp_q.pop_front();
      check_eq("rvalid", bus.bmem_rvalid, 1'b1);
      check_eq("rdata", bus.bmem_rdata, b.d);
      check_eq("raddr", bus.bmem_raddr, b.a);
    end else begin
      check_eq("rvalid_idle", bus.bmem_rvalid, 1'b0);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.bmem_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check_eq("ready_wait", bus.bmem_ready, 1'b1);
  endtask

  // Leaves bmem_read high so consecutive calls issue back-to-back reads.
  task automatic do_read(input logic [31:0] a);
    wait_ready();
    bus.bmem_addr  = a;
    bus.bmem_write = 1'b0;
    bus.bmem_read  = 1'b1;
    step();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [255:0] line, input int nbeats,
                          input bit with_read);
    wait_ready();
    bus.bmem_addr  = a;
    bus.bmem_write = 1'b1;
    bus.bmem_read  = with_read;
    bus.bmem_wdata = line[63:0];
    step();
    bus.bmem_read = 1'b0;
    for (int k = 1; k < nbeats; k++) begin
      bus.bmem_wdata = line[k*64 +: 64];
      step();
    end
    idle();
  endtask

  task automatic do_reset(input int hold);
    idle();
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_rvalid", bus.bmem_rvalid, 1'b0);
    check_eq("rst_ready", bus.bmem_ready, 1'b0);
    repeat (hold) @(posedge clk);
    exp_q.delete();
    pops.delete();
    outstanding = 0;
    next_free   = 0;
    wr_phase    = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int r;
    logic [31:0] a;
    bus.bmem_addr  = '0;
    bus.bmem_wdata = '0;
    idle();
    #1;
    check_eq("rst_ready0", bus.bmem_ready, 1'b0);
    check_eq("rst_rvalid0", bus.bmem_rvalid, 1'b0);
    check_eq("rst_raddr0", bus.bmem_raddr, 32'd0);
    check_eq("rst_rdata0", bus.bmem_rdata, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int i = 0; i < MemLines; i++) do_write(32'(i * 32), rnd_line(), 4, 1'b0);

    // Known line, then a read at an unaligned address inside it
    do_write(32'h100, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 4, 1'b0);
    do_read(32'h104);
    idle();
    steps(8);

    // Fill the queue back-to-back
    do_read(32'h000);
    do_read(32'h020);
    do_read(32'h040);
    do_read(32'h060);
    idle();
    steps(24);

    // Queued read must see pre-write data; later read sees the new line
    do_read(32'h200);
    do_write(32'h200, {4{64'hAAAA_AAAA_AAAA_AAAA}}, 4, 1'b0);
    do_read(32'h200);
    idle();
    steps(12);

    // Read and write together: write only, no burst
    do_write(32'h300, rnd_line(), 4, 1'b1);
    steps(8);

    // Reset mid-burst with reads still queued
    do_read(32'h400);
    do_read(32'h420);
    do_read(32'h440);
    idle();
    n = 0;
    while (bus.bmem_rvalid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check_eq("burst_start", bus.bmem_rvalid, 1'b1);
    step();
    do_reset(2);
    steps(12);

    // Partial write cut by reset leaves the line untouched
    do_write(32'h500, rnd_line(), 3, 1'b0);
    do_reset(1);
    do_read(32'h500);
    idle();
    steps(8);

    // Upper address bits alias
    do_write(32'h0000_2020, rnd_line(), 4, 1'b0);
    do_read(32'h0000_0020);
    idle();
    steps(8);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      if (r < 6)      do_read(a);
      else if (r < 9) do_write(a, rnd_line(), 4, 1'b0);
      else            do_write(a, rnd_line(), 4, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        idle();
        steps($urandom_range(0, 4));
      end
    end

    idle();
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    steps(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
